count_1_to_10: RTL and testbench
================================

# count_1_to_10

Synchronous decade counter that cycles through the values 1 to 10 inclusive, then wraps back to 1. Typical use is as a one-based sequence/phase index or a divide-by-10 time base feeding downstream control logic. It is a single registered counter with no handshake; the count advances on every clock edge unless reset is asserted.

## Interface
Parameters:
- WIDTH, 4: counter/output width in bits; must satisfy 2^WIDTH > MAX_VAL.
- MIN_VAL, 1: reset value and wrap-to value.
- MAX_VAL, 10: terminal count; MIN_VAL < MAX_VAL required, checked at elaboration.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- q  out  WIDTH  current count, driven directly from the state register.

## Operation
- State is one WIDTH-bit register driving `q` directly, with no combinational path from inputs to `q`.
- On a rising edge of `clk`:
  - `reset` = 1: q <= MIN_VAL (1).
  - `reset` = 0, q == MAX_VAL (10): q <= MIN_VAL (1).
  - `reset` = 0, otherwise: q <= q + 1, modulo 2^WIDTH.
- Reset has priority over counting and wrap on the same edge.
- Legal sequence: 1,2,3,4,5,6,7,8,9,10,1,…
- Out-of-range recovery, defined even though unreachable after reset:
  - q = 0 increments to 1.
  - q = 11..15 increments through 15, then 0, then 1.
  - A reset always restores 1.
- No power-on initial value is required. `q` is undefined until the first clock edge sampled with `reset` = 1.

## Timing
- Latency: `q` changes only after a rising edge of `clk`; each edge produces at most one step.
- Reset is strictly synchronous:
  - Asserting or deasserting `reset` between edges (e.g., on the falling edge) must not change `q` until the next rising edge.
  - There is no asynchronous term in the register's sensitivity.
- Reset held for N edges: `q` = 1 after each of those edges. The first edge with `reset` = 0 yields 2.
- Reset asserted mid-count, e.g. at q=7: the next edge gives 1.
- Reset asserted at q=10: the next edge gives 1, the same as a natural wrap.
- Period without reset: exactly 10 cycles. `q` equals 10 for one cycle per period.

## Structure
- Shared package `count_1_to_10_pkg` holds:
  - constants CNT_WIDTH=4, CNT_MIN=1, CNT_MAX=10;
  - typedef `cnt_t` (logic [CNT_WIDTH-1:0]).
- Parameter defaults reference the package constants.
- Single module with one registered process and next-state logic. No sub-module is warranted.
- Include elaboration-time assertions on the parameter constraints.
- Include simulation assertions:
  - after reset, `q` stays within [MIN_VAL, MAX_VAL];
  - q(t+1) == (q(t)==MAX_VAL ? MIN_VAL : q(t)+1) whenever reset(t)=0.

## Test plan
- Reset for 1 edge, then release for 12 edges -> q = 1, then 2,3,4,5,6,7,8,9,10,1,2,3.
- Reset asserted when q=7 -> the next edge gives q=1 and the following edge gives q=2. Reset asserted when q=10 -> the next edge gives q=1.
- Reset held high for 5 consecutive edges -> q stays 1 throughout; the first non-reset edge gives q=2.
- Reset raised on the falling edge and dropped on the next falling edge, with q=4 -> q holds 4 until the rising edge, then becomes 1. This confirms there is no asynchronous reset behaviour.
- Randomized: 400 half-cycles, with `reset` driven high with probability 1/32 on both clock edges -> `q` matches a golden model on every sample (both edges), with zero mismatches.

Source files
------------

// File: rtl/count_1_to_10_pkg.sv
// Shared constants and count type for the one-based decade counter.
package count_1_to_10_pkg;

  localparam int CNT_WIDTH = 4;
  localparam int CNT_MIN   = 1;
  localparam int CNT_MAX   = 10;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/count_1_to_10.sv
// Free-running counter MIN_VAL..MAX_VAL with synchronous active-high reset.
module count_1_to_10
  import count_1_to_10_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH,
  parameter int MIN_VAL = CNT_MIN,
  parameter int MAX_VAL = CNT_MAX
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] LO = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] HI = WIDTH'(MAX_VAL);

  if (MIN_VAL >= MAX_VAL) begin : g_chk_order
    $error("count_1_to_10: MIN_VAL must be below MAX_VAL");
  end
  if ((64'd1 << WIDTH) <= 64'(MAX_VAL)) begin : g_chk_width
    $error("count_1_to_10: WIDTH too narrow for MAX_VAL");
  end

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;

  // Out-of-range values simply increment and wrap through 0 back into range.
  always_comb begin
    w_q_nxt = r_q + WIDTH'(1);
    if (r_q == HI) w_q_nxt = LO;
  end

  always_ff @(posedge clk) begin
    if (reset) r_q <= LO;
    else       r_q <= w_q_nxt;
  end

  assign q = r_q;

`ifndef SYNTHESIS
  // q is meaningless before the first reset edge, so checks wait for it.
  logic r_rst_seen = 1'b0;
  always_ff @(posedge clk) begin
    if (reset) r_rst_seen <= 1'b1;
  end

  a_range: assert property (@(posedge clk) r_rst_seen |-> (q >= LO && q <= HI));
  a_step:  assert property (@(posedge clk) (r_rst_seen && !reset) |=>
                            (q == (($past(q) == HI) ? LO : $past(q) + WIDTH'(1))));
`endif

endmodule

// File: tb/tb_count_1_to_10.sv
// Self-checking bench: directed sequences plus randomized reset against an edges-since-reset model.
module tb_count_1_to_10;

  logic       clk;
  logic       reset;
  logic [3:0] q;

  int n_chk  = 0;
  int n_fail = 0;

  count_1_to_10 dut (
    .clk   (clk),
    .reset (reset),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: q=%0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the count is one plus (edges since the last reset edge) mod 10.
  int m_k     = 0;
  bit m_valid = 1'b0;
  bit cmp_en  = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_k     <= 0;
      m_valid <= 1'b1;
    end else begin
      m_k     <= m_k + 1;
    end
  end

  function automatic int model_q();
    return (m_k % 10) + 1;
  endfunction

  always @(negedge clk) begin
    if (cmp_en && m_valid) check("model_neg", int'(q), model_q());
  end

  always begin
    @(posedge clk);
    #3;
    if (cmp_en && m_valid) check("model_pos", int'(q), model_q());
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  int exp_seq [12] = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 1, 2, 3};

  initial begin
    reset = 1'b1;

    // One reset edge, then a full period and a bit.
    step();
    check("reset_state", int'(q), 1);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check("seq", int'(q), exp_seq[i]);
    end

    // Reset mid-count at 7.
    repeat (4) step();
    check("reach7", int'(q), 7);
    reset = 1'b1;
    step();
    check("rst_at7", int'(q), 1);
    reset = 1'b0;
    step();
    check("after_rst7", int'(q), 2);

    // Reset at the terminal count.
    repeat (8) step();
    check("reach10", int'(q), 10);
    reset = 1'b1;
    step();
    check("rst_at10", int'(q), 1);

    // Reset held for 5 edges in total.
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_hold", int'(q), 1);
    end
    reset = 1'b0;
    step();
    check("hold_release", int'(q), 2);

    // Reset toggled on falling edges: no change until the rising edge.
    repeat (2) step();
    check("reach4", int'(q), 4);
    @(negedge clk);
    reset = 1'b1;
    #4;
    check("sync_hold", int'(q), 4);
    @(posedge clk);
    #1;
    check("sync_rst", int'(q), 1);
    @(negedge clk);
    reset = 1'b0;
    #4;
    check("sync_drop_hold", int'(q), 1);
    @(posedge clk);
    #1;
    check("sync_after", int'(q), 2);

    // Randomized reset on both edges, 400 half-cycles.
    cmp_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      reset = ($urandom_range(31) == 0);
      @(negedge clk);
      reset = ($urandom_range(31) == 0);
    end
    @(posedge clk);
    #1;
    reset  = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
